avr_pin_in: RTL and testbench

Input-side GPIO conditioner for the AVR SoC port B. It synchronises and debounces raw board pads and merges them with output-driven bits to produce the `pin_b` value the core reads. It also raises a masked, sticky pin-change interrupt flag. It sits between the board pads and `avr_soc`, replacing the constant `pin_b` tie-off in board top levels.

---
 rtl/avr_pin_in_pkg.sv | 16 +
 rtl/avr_debounce.sv | 54 +++++
 rtl/avr_pin_in.sv | 60 ++++++
 tb/tb_avr_pin_in.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/avr_pin_in_pkg.sv
// Shared constants for the port-B input conditioner: default debounce length,
// I/O addresses the SoC decoder uses for PINB/PCMSK/PCIFR, and counter sizing.
package avr_pin_in_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 48000;  // 1 ms at 48 MHz

    localparam logic [7:0] PINB_ADDR  = 8'h03;
    localparam logic [7:0] PCMSK_ADDR = 8'h6B;
    localparam logic [7:0] PCIFR_ADDR = 8'h1B;

    // A single-cycle debounce still needs a 1-bit counter to stay legal.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avr_debounce.sv
// One-bit pad conditioner: 2-flop synchroniser followed by a counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module avr_debounce
    import avr_pin_in_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic pad_in,
    output logic stable_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;
    logic          stable_d;

    // Counter stops at CNT_MAX by construction, so it can never wrap.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= pad_in;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/avr_pin_in.sv
// Port-B input conditioner: debounced pads merged with output-driven bits into
// pin_b, plus a masked, sticky pin-change record and interrupt request.
module avr_pin_in
    import avr_pin_in_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] port_b,
    input  logic [WIDTH-1:0] ddr_b,
    input  logic [WIDTH-1:0] pcmsk,
    input  logic             pc_clear,
    output logic [WIDTH-1:0] pin_b,
    output logic [WIDTH-1:0] pc_bits,
    output logic             pc_flag
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] pin_d;
    logic [WIDTH-1:0] pin_q;
    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] pc_bits_d;
    logic [WIDTH-1:0] pc_bits_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        avr_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .pad_in  (pad_in[i]),
            .stable_o(stable[i])
        );
    end

    // Output bits loop back the driven value regardless of the pad level.
    assign pin_d = (ddr_b & port_b) | (~ddr_b & stable);
    assign chg   = (pin_d ^ pin_q) & pcmsk;

    // A clear colliding with a new change keeps the new change.
    assign pc_bits_d = pc_clear ? chg : (pc_bits_q | chg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pin_q     <= '0;
            pc_bits_q <= '0;
        end else begin
            pin_q     <= pin_d;
            pc_bits_q <= pc_bits_d;
        end
    end

    assign pin_b   = pin_q;
    assign pc_bits = pc_bits_q;
    assign pc_flag = |pc_bits_q;

endmodule

// File: tb/tb_avr_pin_in.sv
// Directed bench for avr_pin_in with DEBOUNCE_CYCLES=4 (pad-to-pin latency 7 edges).
module tb_avr_pin_in;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pad_in;
    logic [7:0] port_b;
    logic [7:0] ddr_b;
    logic [7:0] pcmsk;
    logic       pc_clear;
    logic [7:0] pin_b;
    logic [7:0] pc_bits;
    logic       pc_flag;

    int vectors    = 0;
    int miscompares = 0;

    avr_pin_in #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pad_in  (pad_in),
        .port_b  (port_b),
        .ddr_b   (ddr_b),
        .pcmsk   (pcmsk),
        .pc_clear(pc_clear),
        .pin_b   (pin_b),
        .pc_bits (pc_bits),
        .pc_flag (pc_flag)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b0;
        pad_in   = 8'hFF;
        port_b   = 8'h00;
        ddr_b    = 8'h00;
        pcmsk    = 8'h00;
        pc_clear = 1'b0;

        // Reset and power-up with pads high
        tick(3);
        chk("rst_pin_b", pin_b, 8'h00);
        chk("rst_pc_bits", pc_bits, 8'h00);
        chk("rst_pc_flag", {7'b0, pc_flag}, 8'h00);
        reset = 1'b1;
        tick(6);
        chk("pwr_pin_b_e6", pin_b, 8'h00);
        tick(1);
        chk("pwr_pin_b_e7", pin_b, 8'hFF);
        chk("pwr_pc_flag", {7'b0, pc_flag}, 8'h00);

        // Pads low, unmasked fall
        pad_in = 8'h00;
        tick(7);
        chk("fall_pin_b", pin_b, 8'h00);
        chk("fall_pc_bits", pc_bits, 8'h00);

        // Glitch of 3 cycles on bit0 is rejected
        pcmsk  = 8'h01;
        pad_in = 8'h01;
        tick(3);
        pad_in = 8'h00;
        tick(10);
        chk("glitch_pin_b", pin_b, 8'h00);
        chk("glitch_pc_flag", {7'b0, pc_flag}, 8'h00);

        // Held high on bit0 is accepted on edge 7
        pad_in = 8'h01;
        tick(6);
        chk("accept_pin_b_e6", pin_b, 8'h00);
        chk("accept_pc_bits_e6", pc_bits, 8'h00);
        tick(1);
        chk("accept_pin_b_e7", pin_b, 8'h01);
        chk("accept_pc_bits_e7", pc_bits, 8'h01);
        chk("accept_pc_flag_e7", {7'b0, pc_flag}, 8'h01);

        // Clear, then output loopback on bit2
        pc_clear = 1'b1;
        tick(1);
        pc_clear = 1'b0;
        chk("clr_pc_bits", pc_bits, 8'h00);
        ddr_b  = 8'h04;
        port_b = 8'h04;
        pcmsk  = 8'h04;
        tick(1);
        chk("loop_pin_b", pin_b, 8'h05);
        chk("loop_pc_bits", pc_bits, 8'h04);
        chk("loop_pc_flag", {7'b0, pc_flag}, 8'h01);

        // Build pc_bits=01 from a masked bit0 fall
        pc_clear = 1'b1;
        tick(1);
        pc_clear = 1'b0;
        pad_in   = 8'h00;
        pcmsk    = 8'h01;
        tick(7);
        chk("pre_coll_pin_b", pin_b, 8'h04);
        chk("pre_coll_pc_bits", pc_bits, 8'h01);

        // Clear lands on the same edge as a masked bit1 rise
        pcmsk  = 8'h03;
        pad_in = 8'h02;
        tick(6);
        chk("coll_pc_bits_e6", pc_bits, 8'h01);
        pc_clear = 1'b1;
        tick(1);
        pc_clear = 1'b0;
        chk("coll_pin_b", pin_b, 8'h06);
        chk("coll_pc_bits", pc_bits, 8'h02);
        chk("coll_pc_flag", {7'b0, pc_flag}, 8'h01);
        pc_clear = 1'b1;
        tick(1);
        pc_clear = 1'b0;
        chk("clr2_pc_bits", pc_bits, 8'h00);
        chk("clr2_pc_flag", {7'b0, pc_flag}, 8'h00);

        // Reset two cycles into a bit3 debounce
        ddr_b  = 8'h00;
        port_b = 8'h00;
        pcmsk  = 8'h00;
        pad_in = 8'h0A;
        tick(4);
        chk("mid_pin_b_before", pin_b, 8'h02);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_pin_b", pin_b, 8'h00);
        chk("mid_rst_pc_flag", {7'b0, pc_flag}, 8'h00);
        tick(2);
        reset = 1'b1;
        tick(6);
        chk("mid_rel_pin_b_e6", pin_b, 8'h00);
        tick(1);
        chk("mid_rel_pin_b_e7", pin_b, 8'h0A);

        // Mask isolation
        pad_in = 8'hF5;
        tick(7);
        chk("mask_pin_b", pin_b, 8'hF5);
        chk("mask_pc_bits", pc_bits, 8'h00);
        pcmsk = 8'hFF;
        tick(3);
        chk("mask_set_pc_bits", pc_bits, 8'h00);
        chk("mask_set_pc_flag", {7'b0, pc_flag}, 8'h00);
        pad_in = 8'hF4;
        tick(7);
        chk("mask_new_pin_b", pin_b, 8'hF4);
        chk("mask_new_pc_bits", pc_bits, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
